// File: rtl/proc_core_pkg.sv
// Shared definitions for the parametrised bus processor: opcodes, FSM states
// and IR field placement as functions of the register-index width.
package proc_core_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MVNZ = 3'b111;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_e;

  function automatic int irWidth(input int rw);
    return 3 + 2 * rw;
  endfunction

  function automatic int opLsb(input int rw);
    return 2 * rw;
  endfunction

  function automatic int xLsb(input int rw);
    return rw;
  endfunction

endpackage

// File: rtl/proc_alu_n.sv
// Combinational ALU: add/sub/and/or/xor, modulo 2^DATA_W, with a zero flag.
module proc_alu_n
  import proc_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/proc_core_n.sv
// Multi-cycle bus processor: NREG general registers, A/G registers, one ALU
// and a single shared bus; one instruction per Run request, Done on completion.
module proc_core_n
  import proc_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] Bus,
  output logic              Done,
  output logic              Busy,
  output logic              Zflag
);

  localparam int RW   = $clog2(NREG);
  localparam int IR_W = irWidth(RW);

  if (IR_W > DATA_W) begin : gIrTooWide
    $error("proc_core_n: instruction width exceeds DATA_W");
  end
  if (NREG < 2 || (1 << RW) != NREG) begin : gBadNreg
    $error("proc_core_n: NREG must be a power of two and at least 2");
  end

  state_e              state_q, state_d;
  logic [IR_W-1:0]     ir_q;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   g_q;
  logic                z_q;

  logic [2:0]          op;
  logic [RW-1:0]       rx;
  logic [RW-1:0]       ry;
  logic                irLoad;
  logic                regWr;
  logic                aLoad;
  logic                gLoad;
  logic [DATA_W-1:0]   aluResult;
  logic                aluZero;

  assign op = ir_q[opLsb(RW) +: 3];
  assign rx = ir_q[xLsb(RW) +: RW];
  assign ry = ir_q[RW-1:0];

  proc_alu_n #(.DATA_W(DATA_W)) uAlu (
    .op_i    (op),
    .a_i     (a_q),
    .b_i     (Bus),
    .result_o(aluResult),
    .zero_o  (aluZero)
  );

  // Every register write takes its data from the bus, so one mux serves all moves.
  always_comb begin
    state_d = state_q;
    Bus     = DIN;
    Done    = 1'b0;
    irLoad  = 1'b0;
    regWr   = 1'b0;
    aLoad   = 1'b0;
    gLoad   = 1'b0;
    case (state_q)
      T0: begin
        if (Run) begin
          irLoad  = 1'b1;
          state_d = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            Bus     = regs_q[ry];
            regWr   = 1'b1;
            Done    = 1'b1;
            state_d = T0;
          end
          OP_MVI: begin
            Bus     = DIN;
            regWr   = 1'b1;
            Done    = 1'b1;
            state_d = T0;
          end
          OP_MVNZ: begin
            Bus     = regs_q[ry];
            regWr   = ~z_q;
            Done    = 1'b1;
            state_d = T0;
          end
          default: begin
            Bus     = regs_q[rx];
            aLoad   = 1'b1;
            state_d = T2;
          end
        endcase
      end
      T2: begin
        Bus     = regs_q[ry];
        gLoad   = 1'b1;
        state_d = T3;
      end
      T3: begin
        Bus     = g_q;
        regWr   = 1'b1;
        Done    = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q    <= '0;
      regs_q  <= '{default: '0};
      a_q     <= '0;
      g_q     <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (irLoad) ir_q <= DIN[IR_W-1:0];
      if (regWr)  regs_q[rx] <= Bus;
      if (aLoad)  a_q <= Bus;
      if (gLoad) begin
        g_q <= aluResult;
        z_q <= aluZero;
      end
    end
  end

  assign Busy  = (state_q != T0);
  assign Zflag = z_q;

endmodule

// File: tb/tb_proc_core_n.sv
// Self-checking bench: drives an 8-bit/4-reg and a 16-bit/8-reg core in lockstep
// and compares both against an instruction-level model every cycle.
module tb_proc_core_n;

  logic        Clk = 1'b0;
  logic        Resetn = 1'b0;
  logic        Run = 1'b0;
  logic [7:0]  din8 = '0;
  logic [15:0] din16 = '0;
  logic [7:0]  bus8;
  logic [15:0] bus16;
  logic        done8, busy8, z8;
  logic        done16, busy16, z16;

  int nTests = 0;
  int nFail  = 0;

  always #5 Clk = ~Clk;

  proc_core_n #(.DATA_W(8), .NREG(4)) dut8 (
    .Clk(Clk), .Resetn(Resetn), .Run(Run), .DIN(din8),
    .Bus(bus8), .Done(done8), .Busy(busy8), .Zflag(z8)
  );

  proc_core_n #(.DATA_W(16), .NREG(8)) dut16 (
    .Clk(Clk), .Resetn(Resetn), .Run(Run), .DIN(din16),
    .Bus(bus16), .Done(done16), .Busy(busy16), .Zflag(z16)
  );

  // Instruction-level model: architectural registers per configuration plus
  // the cycle index within the instruction currently executing.
  int unsigned mReg [2][8];
  bit          mZ [2];
  int unsigned mRes [2];
  int          mStep = 0;
  int          mOp = 0, mX = 0, mY = 0;
  int          curOp = 0, curX = 0, curY = 0;
  int unsigned mask [2] = '{32'hFF, 32'hFFFF};

  function automatic int unsigned aluModel(input int op, input int unsigned a,
                                           input int unsigned b, input int unsigned m);
    case (op)
      2: return (a + b) & m;
      3: return (a - b) & m;
      4: return a & b;
      5: return a | b;
      6: return a ^ b;
      default: return 0;
    endcase
  endfunction

  always @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      mStep <= 0;
      for (int c = 0; c < 2; c++) begin
        mZ[c]   <= 1'b0;
        mRes[c] <= 0;
        for (int k = 0; k < 8; k++) mReg[c][k] <= 0;
      end
    end else begin
      case (mStep)
        0: if (Run) begin
          mOp <= curOp; mX <= curX; mY <= curY; mStep <= 1;
        end
        1: begin
          mStep <= (mOp >= 2 && mOp <= 6) ? 2 : 0;
          for (int c = 0; c < 2; c++) begin
            if (mOp == 0 || (mOp == 7 && !mZ[c])) mReg[c][mX] <= mReg[c][mY];
            if (mOp == 1) mReg[c][mX] <= (c == 0) ? {24'b0, din8} : {16'b0, din16};
          end
        end
        2: begin
          mStep <= 3;
          for (int c = 0; c < 2; c++) begin
            mRes[c] <= aluModel(mOp, mReg[c][mX], mReg[c][mY], mask[c]);
            mZ[c]   <= (aluModel(mOp, mReg[c][mX], mReg[c][mY], mask[c]) == 0);
          end
        end
        default: begin
          mStep <= 0;
          for (int c = 0; c < 2; c++) mReg[c][mX] <= mRes[c];
        end
      endcase
    end
  end

  function automatic logic [31:0] expBus(input int c);
    logic [31:0] d;
    d = (c == 0) ? {24'b0, din8} : {16'b0, din16};
    case (mStep)
      0: return d;
      1: begin
        if (mOp == 1) return d;
        if (mOp == 0 || mOp == 7) return mReg[c][mY];
        return mReg[c][mX];
      end
      2: return mReg[c][mY];
      default: return mRes[c];
    endcase
  endfunction

  function automatic logic expDone();
    return (mStep == 1 && (mOp == 0 || mOp == 1 || mOp == 7)) || mStep == 3;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    checkOutput("bus8",   {24'b0, bus8},   expBus(0));
    checkOutput("done8",  {31'b0, done8},  {31'b0, expDone()});
    checkOutput("busy8",  {31'b0, busy8},  {31'b0, mStep != 0});
    checkOutput("z8",     {31'b0, z8},     {31'b0, mZ[0]});
    checkOutput("bus16",  {16'b0, bus16},  expBus(1));
    checkOutput("done16", {31'b0, done16}, {31'b0, expDone()});
    checkOutput("busy16", {31'b0, busy16}, {31'b0, mStep != 0});
    checkOutput("z16",    {31'b0, z16},    {31'b0, mZ[1]});
  end

  function automatic logic [7:0] enc8(input int op, input int x, input int y);
    return 8'((op << 4) | (x << 2) | y);
  endfunction

  function automatic logic [15:0] enc16(input int op, input int x, input int y);
    return 16'((op << 6) | (x << 3) | y);
  endfunction

  // Called just after a rising edge while the cores are idle; returns the
  // number of edges until Busy drops, Done pulses seen, and the T1 bus values.
  task automatic applyStimulus(input int op, input int x, input int y, input int unsigned imm,
                               output int cycles, output int dones,
                               output logic [7:0] t1Bus8, output logic [15:0] t1Bus16);
    curOp = op; curX = x; curY = y;
    Run = 1'b1; din8 = enc8(op, x, y); din16 = enc16(op, x, y);
    @(posedge Clk); #1;
    Run = 1'b0; din8 = imm[7:0]; din16 = imm[15:0];
    cycles = 1; dones = 0; t1Bus8 = '0; t1Bus16 = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (i == 0) begin t1Bus8 = bus8; t1Bus16 = bus16; end
      if (done8) dones++;
      @(posedge Clk); #1;
      if (!busy8) return;
      cycles++;
    end
    checkOutput("timeout", 32'd1, 32'd0);
  endtask

  task automatic runInstr(input int op, input int x, input int y, input int unsigned imm);
    int cyc, dn;
    logic [7:0] b8;
    logic [15:0] b16;
    applyStimulus(op, x, y, imm, cyc, dn, b8, b16);
    checkOutput("latency", cyc, (op >= 2 && op <= 6) ? 3 : 1);
    checkOutput("donecount", dn, 1);
  endtask

  task automatic readReg(input int k, input int unsigned exp8, input int unsigned exp16);
    int cyc, dn;
    logic [7:0] b8;
    logic [15:0] b16;
    applyStimulus(0, k, k, 0, cyc, dn, b8, b16);
    checkOutput($sformatf("R%0d_8", k), {24'b0, b8}, exp8);
    checkOutput($sformatf("R%0d_16", k), {16'b0, b16}, exp16);
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("rst_busy", {31'b0, busy8}, 0);
    checkOutput("rst_done", {31'b0, done8}, 0);
    checkOutput("rst_z", {31'b0, z16}, 0);
    checkOutput("rst_bus", {24'b0, bus8}, 0);
    Resetn = 1'b1;
    @(posedge Clk); #1;

    runInstr(1, 0, 0, 32'h0005);
    runInstr(1, 1, 0, 32'h0003);
    readReg(0, 32'h05, 32'h0005);
    readReg(1, 32'h03, 32'h0003);

    runInstr(2, 0, 1, 0);
    checkOutput("z_after_add", {30'b0, z16, z8}, 0);
    readReg(0, 32'h08, 32'h0008);

    runInstr(3, 1, 0, 0);
    readReg(1, 32'hFB, 32'hFFFB);
    runInstr(6, 1, 1, 0);
    checkOutput("z_after_xor", {30'b0, z16, z8}, 32'h3);
    readReg(1, 32'h00, 32'h0000);

    runInstr(7, 2, 0, 0);
    readReg(2, 32'h00, 32'h0000);
    runInstr(5, 3, 0, 0);
    checkOutput("z_after_or", {30'b0, z16, z8}, 0);
    runInstr(7, 2, 0, 0);
    readReg(2, 32'h08, 32'h0008);

    runInstr(1, 0, 0, 32'h12C3);
    runInstr(1, 1, 0, 32'h345A);
    runInstr(4, 0, 1, 0);
    readReg(0, 32'h42, 32'h1042);

    // Abort an add during T2 with an asynchronous reset.
    curOp = 2; curX = 0; curY = 1;
    Run = 1'b1; din8 = enc8(2, 0, 1); din16 = enc16(2, 0, 1);
    @(posedge Clk); #1;
    Run = 1'b0; din8 = '0; din16 = '0;
    @(posedge Clk); #1;
    checkOutput("in_t2_busy", {31'b0, busy8}, 1);
    Resetn = 1'b0;
    #1;
    checkOutput("abort_busy", {30'b0, busy16, busy8}, 0);
    checkOutput("abort_bus", {24'b0, bus8}, 0);
    @(posedge Clk); #1;
    Resetn = 1'b1;
    @(posedge Clk); #1;
    readReg(0, 0, 0);
    readReg(1, 0, 0);
    readReg(2, 0, 0);
    checkOutput("abort_z", {30'b0, z16, z8}, 0);

    // Idle for ten cycles, then a Run pulse during T2 must be ignored.
    runInstr(1, 1, 0, 32'h0077);
    repeat (10) @(posedge Clk);
    #1;
    checkOutput("idle_busy", {31'b0, busy8}, 0);
    curOp = 2; curX = 1; curY = 1;
    Run = 1'b1; din8 = enc8(2, 1, 1); din16 = enc16(2, 1, 1);
    @(posedge Clk); #1;
    Run = 1'b0;
    @(posedge Clk); #1;
    curOp = 1; curX = 3; curY = 0;
    Run = 1'b1; din8 = enc8(1, 3, 0); din16 = enc16(1, 3, 0);
    @(posedge Clk); #1;
    Run = 1'b0; din8 = '0; din16 = '0;
    @(posedge Clk); #1;
    checkOutput("after_pulse_busy", {31'b0, busy8}, 0);
    readReg(1, 32'hEE, 32'h00EE);
    readReg(3, 0, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
